// File: rtl/deinterleaver_pkg.sv
// deinterleaver_pkg: 802.11a rate codes, per-rate N_CBPS/N_BPSC mapping and index helpers
package deinterleaver_pkg;
   localparam logic [3:0] RATE_6M  = 4'b1101;
   localparam logic [3:0] RATE_9M  = 4'b1111;
   localparam logic [3:0] RATE_12M = 4'b0101;
   localparam logic [3:0] RATE_18M = 4'b0111;
   localparam logic [3:0] RATE_24M = 4'b1001;
   localparam logic [3:0] RATE_36M = 4'b1011;
   localparam logic [3:0] RATE_48M = 4'b0001;
   localparam logic [3:0] RATE_54M = 4'b0011;
   localparam logic [8:0] CBPS_BPSK  = 9'd48;
   localparam logic [8:0] CBPS_QPSK  = 9'd96;
   localparam logic [8:0] CBPS_16QAM = 9'd192;
   localparam logic [8:0] CBPS_64QAM = 9'd288;
   localparam logic [2:0] BPSC_BPSK  = 3'd1;
   localparam logic [2:0] BPSC_QPSK  = 3'd2;
   localparam logic [2:0] BPSC_16QAM = 3'd4;
   localparam logic [2:0] BPSC_64QAM = 3'd6;
   typedef enum logic {RD_IDLE, RD_DRAIN} rd_state_t;
   function automatic logic [8:0] rate_cbps(input logic [3:0] rate);
      case (rate)
         RATE_12M, RATE_18M: return CBPS_QPSK;
         RATE_24M, RATE_36M: return CBPS_16QAM;
         RATE_48M, RATE_54M: return CBPS_64QAM;
         default:            return CBPS_BPSK;
      endcase
   endfunction
   function automatic logic [2:0] rate_bpsc(input logic [3:0] rate);
      case (rate)
         RATE_12M, RATE_18M: return BPSC_QPSK;
         RATE_24M, RATE_36M: return BPSC_16QAM;
         RATE_48M, RATE_54M: return BPSC_64QAM;
         default:            return BPSC_BPSK;
      endcase
   endfunction
   // s = max(N_BPSC/2, 1): 1,2 -> 1; 4 -> 2; 6 -> 3
   function automatic logic [1:0] spread(input logic [2:0] bpsc);
      return bpsc >= 3'd4 ? bpsc[2:1] : 2'd1;
   endfunction
   // floor(16x/N_CBPS) by comparing x against multiples of N_CBPS/16
   function automatic logic [3:0] frac16(input logic [8:0] x, input logic [8:0] c16);
      logic [3:0] f;
      f = 4'd0;
      for (int m = 1; m < 16; m++)
         if (x >= 9'(m) * c16) f = 4'(m);
      return f;
   endfunction
endpackage

// File: rtl/deinterleaver_index.sv
// deint_index: maps received bit index j to de-interleaved position k
// ports: cbps (N_CBPS), s (spread), j (received index) -> k (output position)
module deint_index
   import deinterleaver_pkg::*;
(
   input  logic [8:0] cbps,
   input  logic [1:0] s,
   input  logic [8:0] j,
   output logic [8:0] k
);
   logic [8:0] c16, jf, base, off, i;
   logic [3:0] f, g;
   always_comb begin
      c16  = cbps >> 4;
      f    = frac16(j, c16);
      jf   = j + 9'(f);
      base = s == 2'd3 ? j - j % 9'd3 : s == 2'd2 ? {j[8:1], 1'b0} : j;
      off  = s == 2'd3 ? jf % 9'd3 : s == 2'd2 ? {8'd0, jf[0]} : 9'd0;
      i    = base + off;
      g    = frac16(i, c16);
      k    = 9'({i, 4'b0000} - 13'(cbps - 9'd1) * 13'(g));
   end
endmodule

// File: rtl/deinterleaver.sv
// deinterleaver: 802.11a receive-side block de-interleaver, ping-pong buffered AXI-Stream
// ports: aclk/areset; s_axis_* interleaved bits + rate in; m_axis_* de-interleaved bits + latched rate out
module deinterleaver
   import deinterleaver_pkg::*;
#(
   parameter int WIDTH    = 8,
   parameter int MAX_CBPS = 288
) (
   input  logic               aclk,
   input  logic               areset,
   input  logic [WIDTH-1:0]   s_axis_tdata,
   input  logic [WIDTH/2-1:0] s_axis_tuser,
   input  logic               s_axis_tvalid,
   output logic               s_axis_tready,
   output logic [WIDTH-1:0]   m_axis_tdata,
   output logic [WIDTH/2-1:0] m_axis_tuser,
   output logic               m_axis_tvalid,
   input  logic               m_axis_tready
);
   logic [MAX_CBPS-1:0] mem [2];
   logic [WIDTH/2-1:0]  rate_q [2];
   logic [1:0]          full, avail;
   logic                wr_bank, rd_bank, acc_in, acc_out, wr_done, rd_done;
   logic [5:0]          wr_cnt, rd_cnt;
   logic [WIDTH/2-1:0]  wr_rate;
   logic [8:0]          wr_cbps, rd_cbps;
   logic [1:0]          wr_s;
   logic [8:0]          k [WIDTH];
   logic [WIDTH-1:0]    rd_data;
   rd_state_t           state, state_nxt;
   // rate comes straight from tuser on the first beat, then from the bank's latch
   assign wr_rate       = wr_cnt == 6'd0 ? s_axis_tuser : rate_q[wr_bank];
   assign wr_cbps       = rate_cbps(wr_rate);
   assign wr_s          = spread(rate_bpsc(wr_rate));
   assign rd_cbps       = rate_cbps(rate_q[rd_bank]);
   assign s_axis_tready = !full[wr_bank];
   assign acc_in        = s_axis_tvalid && s_axis_tready;
   assign acc_out       = m_axis_tvalid && m_axis_tready;
   assign wr_done       = acc_in && wr_cnt == 6'(wr_cbps >> 3) - 6'd1;
   assign rd_done       = acc_out && rd_cnt == 6'(rd_cbps >> 3) - 6'd1;
   // full flags as they will be next cycle, so drain starts right after the last write
   assign avail         = full | (2'(wr_done) << wr_bank);
   for (genvar l = 0; l < WIDTH; l++) begin : g_lane
      deint_index u_idx (.cbps(wr_cbps), .s(wr_s), .j({wr_cnt, 3'(l)}), .k(k[l]));
      assign rd_data[WIDTH-1-l] = mem[rd_bank][{rd_cnt, 3'(l)}];
   end
   always_ff @(posedge aclk)
      if (acc_in)
         for (int l = 0; l < WIDTH; l++) mem[wr_bank][k[l]] <= s_axis_tdata[WIDTH-1-l];
   always_ff @(posedge aclk or posedge areset)
      if (areset) begin
         full      <= '0;
         wr_bank   <= 1'b0;
         rd_bank   <= 1'b0;
         wr_cnt    <= '0;
         rd_cnt    <= '0;
         rate_q[0] <= '0;
         rate_q[1] <= '0;
      end else begin
         if (acc_in) begin
            rate_q[wr_bank] <= wr_rate;
            wr_cnt          <= wr_done ? 6'd0 : wr_cnt + 6'd1;
         end
         if (wr_done) begin
            full[wr_bank] <= 1'b1;
            wr_bank       <= !wr_bank;
         end
         if (acc_out) rd_cnt <= rd_done ? 6'd0 : rd_cnt + 6'd1;
         if (rd_done) begin
            full[rd_bank] <= 1'b0;
            rd_bank       <= !rd_bank;
         end
      end
   always_ff @(posedge aclk or posedge areset)
      if (areset) state <= RD_IDLE;
      else state <= state_nxt;
   always_comb
      state_nxt = state == RD_IDLE ? (avail[rd_bank] ? RD_DRAIN : RD_IDLE)
                : !rd_done ? RD_DRAIN : avail[!rd_bank] ? RD_DRAIN : RD_IDLE;
   always_comb begin
      m_axis_tvalid = state == RD_DRAIN;
      m_axis_tdata  = m_axis_tvalid ? rd_data : '0;
      m_axis_tuser  = m_axis_tvalid ? rate_q[rd_bank] : '0;
   end
endmodule

// File: tb/tb_deinterleaver.sv
// tb_deinterleaver: random loopback against a forward-interleaver reference model
module tb_deinterleaver;
   import deinterleaver_pkg::*;
   typedef struct {logic [7:0] data; logic [3:0] user;} beat_t;
   logic       aclk = 0, areset = 1;
   logic [7:0] s_axis_tdata = 0, m_axis_tdata;
   logic [3:0] s_axis_tuser = 0, m_axis_tuser;
   logic       s_axis_tvalid = 0, s_axis_tready, m_axis_tvalid, m_axis_tready = 0;
   beat_t      in_q[$], exp_q[$];
   int         n_assert = 0, n_fail = 0, a, extra;
   bit         pend = 0;
   logic [3:0] rates [8] = '{RATE_6M, RATE_9M, RATE_12M, RATE_18M, RATE_24M, RATE_36M, RATE_48M, RATE_54M};
   always #5 aclk = ~aclk;
   deinterleaver dut (
      .aclk(aclk), .areset(areset),
      .s_axis_tdata(s_axis_tdata), .s_axis_tuser(s_axis_tuser),
      .s_axis_tvalid(s_axis_tvalid), .s_axis_tready(s_axis_tready),
      .m_axis_tdata(m_axis_tdata), .m_axis_tuser(m_axis_tuser),
      .m_axis_tvalid(m_axis_tvalid), .m_axis_tready(m_axis_tready)
   );
   function automatic int ref_cbps(logic [3:0] r);
      case (r)
         RATE_12M, RATE_18M: return 96;
         RATE_24M, RATE_36M: return 192;
         RATE_48M, RATE_54M: return 288;
         default:            return 48;
      endcase
   endfunction
   function automatic int ref_bpsc(logic [3:0] r);
      return ref_cbps(r) / 48;
   endfunction
   task automatic chk(string tag, logic [31:0] got, logic [31:0] want);
      n_assert++;
      assert (got === want) else begin
         n_fail++;
         $error("FAIL %s: got %0h want %0h", tag, got, want);
      end
   endtask
   // build one symbol with the forward 802.11a interleaver; expect the original bits back
   task automatic add_symbol(logic [3:0] rate, logic [3:0] mid);
      int n, s, i, j;
      bit d [288];
      bit x [288];
      logic [7:0] bx, bd;
      n = ref_cbps(rate);
      s = ref_bpsc(rate) / 2;
      if (s < 1) s = 1;
      for (int q = 0; q < n; q++) d[q] = 1'($urandom);
      for (int q = 0; q < n; q++) begin
         i = (n / 16) * (q % 16) + q / 16;
         j = s * (i / s) + (i + n - (16 * i) / n) % s;
         x[j] = d[q];
      end
      for (int b = 0; b < n / 8; b++) begin
         for (int l = 0; l < 8; l++) begin
            bx[7-l] = x[8*b+l];
            bd[7-l] = d[8*b+l];
         end
         in_q.push_back('{data: bx, user: b == 0 ? rate : mid});
         exp_q.push_back('{data: bd, user: rate});
      end
   endtask
   task automatic run(int max, bit rv, bit rr);
      int  cyc;
      bit  acc;
      cyc = 0;
      while ((in_q.size() > 0 || exp_q.size() > 0) && cyc < max) begin
         @(negedge aclk);
         if (!pend) s_axis_tvalid = in_q.size() > 0 && (!rv || $urandom_range(0, 3) != 0);
         if (s_axis_tvalid) begin
            s_axis_tdata = in_q[0].data;
            s_axis_tuser = in_q[0].user;
         end
         m_axis_tready = !rr || $urandom_range(0, 3) != 0;
         #1;
         acc = s_axis_tvalid && s_axis_tready;
         if (m_axis_tvalid && m_axis_tready) begin
            if (exp_q.size() == 0) chk("extra_beat", 32'(m_axis_tvalid), 0);
            else begin
               chk("data", 32'(m_axis_tdata), 32'(exp_q[0].data));
               chk("user", 32'(m_axis_tuser), 32'(exp_q[0].user));
               void'(exp_q.pop_front());
            end
         end
         @(posedge aclk);
         if (acc) void'(in_q.pop_front());
         pend = s_axis_tvalid && !acc;
         cyc++;
      end
      chk("run_left", 32'(in_q.size() + exp_q.size()), 0);
   endtask
   task automatic feed(input int cycles, output int acc_cnt);
      bit acc;
      acc_cnt = 0;
      for (int c = 0; c < cycles; c++) begin
         @(negedge aclk);
         s_axis_tvalid = in_q.size() > 0;
         if (s_axis_tvalid) begin
            s_axis_tdata = in_q[0].data;
            s_axis_tuser = in_q[0].user;
         end
         #1;
         acc = s_axis_tvalid && s_axis_tready;
         @(posedge aclk);
         if (acc) begin
            void'(in_q.pop_front());
            acc_cnt++;
         end
      end
   endtask
   task automatic drop_valid;
      @(negedge aclk);
      s_axis_tvalid = 0;
      pend = 0;
   endtask
   initial begin
      repeat (2) @(negedge aclk);
      #1;
      chk("rst_tvalid", 32'(m_axis_tvalid), 0);
      chk("rst_tdata", 32'(m_axis_tdata), 0);
      chk("rst_tuser", 32'(m_axis_tuser), 0);
      chk("rst_tready", 32'(s_axis_tready), 1);
      @(negedge aclk) areset = 0;
      // single set bit at j=1 lands at k=16
      in_q.push_back('{data: 8'h40, user: RATE_6M});
      repeat (5) in_q.push_back('{data: 8'h00, user: RATE_6M});
      exp_q.push_back('{data: 8'h00, user: RATE_6M});
      exp_q.push_back('{data: 8'h00, user: RATE_6M});
      exp_q.push_back('{data: 8'h80, user: RATE_6M});
      repeat (3) exp_q.push_back('{data: 8'h00, user: RATE_6M});
      run(200, 0, 0);
      drop_valid();
      // latency: output valid the cycle after the last input beat, held under backpressure
      m_axis_tready = 0;
      add_symbol(RATE_36M, RATE_36M);
      feed(24, a);
      chk("lat_acc", 32'(a), 24);
      #1;
      chk("lat_valid", 32'(m_axis_tvalid), 1);
      drop_valid();
      repeat (5) @(negedge aclk);
      #1;
      chk("hold_data", 32'(m_axis_tdata), 32'(exp_q[0].data));
      chk("hold_user", 32'(m_axis_tuser), 32'(RATE_36M));
      run(300, 0, 0);
      drop_valid();
      // loopback at every rate with random gaps on both sides
      foreach (rates[r]) repeat (3) add_symbol(rates[r], rates[r]);
      run(20000, 1, 1);
      drop_valid();
      // tuser changes mid-symbol are ignored
      add_symbol(RATE_36M, RATE_6M);
      run(500, 0, 1);
      drop_valid();
      // both banks full stops the input side after 72 beats at 54M
      m_axis_tready = 0;
      repeat (3) add_symbol(RATE_54M, RATE_54M);
      feed(100, a);
      chk("bp_acc", 32'(a), 72);
      drop_valid();
      #1;
      chk("bp_tready", 32'(s_axis_tready), 0);
      chk("bp_tvalid", 32'(m_axis_tvalid), 1);
      chk("bp_data", 32'(m_axis_tdata), 32'(exp_q[0].data));
      run(2000, 0, 1);
      drop_valid();
      // reset mid-symbol discards the partial symbol
      m_axis_tready = 1;
      add_symbol(RATE_36M, RATE_36M);
      feed(10, a);
      chk("pre_rst_acc", 32'(a), 10);
      drop_valid();
      areset = 1;
      #1;
      chk("mid_rst_tvalid", 32'(m_axis_tvalid), 0);
      chk("mid_rst_tready", 32'(s_axis_tready), 1);
      @(negedge aclk) areset = 0;
      in_q.delete();
      exp_q.delete();
      add_symbol(RATE_36M, RATE_36M);
      run(1000, 1, 1);
      drop_valid();
      m_axis_tready = 1;
      extra = 0;
      repeat (40) begin
         @(negedge aclk);
         #1;
         if (m_axis_tvalid) extra++;
      end
      chk("no_extra", 32'(extra), 0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end
endmodule
